// File: rtl/coeff_writer.sv
// Coefficient loader: parses framed tap bytes, checks the XOR checksum,
// then burst-writes eight 16-bit taps into the coefficient RAM.
module coeff_writer #(
  parameter int         NUM_TAPS = 8,
  parameter logic [3:0] HDR_TAG  = 4'hA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        abort,
  output logic        in_ready,
  output logic        wr_en,
  output logic [6:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHK,
    COMMIT
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  count;
  logic [3:0]  filter;
  logic [7:0]  csum;
  logic [7:0]  tap_hi [NUM_TAPS];
  logic [7:0]  tap_lo [NUM_TAPS];

  logic        acc;
  logic        hdr_ok;
  logic        csum_ok;
  logic        last_wr;
  logic [2:0]  nk;

  // abort masks acceptance, so a byte presented with it is dropped
  assign acc     = in_valid & in_ready & ~abort;
  assign hdr_ok  = (in_byte[7:4] == HDR_TAG);
  assign csum_ok = (in_byte == csum);
  assign last_wr = (wr_addr[2:0] == 3'd7);
  assign nk      = wr_addr[2:0] + 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (acc && hdr_ok) state_nx = LOAD;
      LOAD: begin
        if (abort)                    state_nx = IDLE;
        else if (acc && count == 4'd15) state_nx = CHK;
      end
      CHK: begin
        if (abort)    state_nx = IDLE;
        else if (acc) state_nx = csum_ok ? COMMIT : IDLE;
      end
      COMMIT: if (last_wr) state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state != COMMIT);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      filter  <= '0;
      csum    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc) begin
            if (hdr_ok) begin
              filter <= in_byte[3:0];
              csum   <= in_byte;
              count  <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (acc) begin
            csum  <= csum ^ in_byte;
            count <= count + 4'd1;
          end
        end
        CHK: begin
          if (acc) begin
            if (csum_ok) begin
              wr_en   <= 1'b1;
              wr_addr <= {filter, 3'd0};
              wr_data <= {tap_hi[0], tap_lo[0]};
            end else begin
              err <= 1'b1;
            end
          end
        end
        COMMIT: begin
          if (last_wr) begin
            wr_en <= 1'b0;
            done  <= 1'b1;
          end else begin
            wr_addr <= {filter, nk};
            wr_data <= {tap_hi[nk], tap_lo[nk]};
          end
        end
      endcase
    end
  end

  // tap buffer needs no reset: only taps of the current frame are read
  always_ff @(posedge clk) begin
    if (state == LOAD && acc) begin
      if (count[0]) tap_lo[count[3:1]] <= in_byte;
      else          tap_hi[count[3:1]] <= in_byte;
    end
  end

endmodule

// File: tb/tb_coeff_writer.sv
// Randomized scoreboard bench for coeff_writer.
// Expected writes/pulses queued by the driver, consumed by a monitor.
module tb_coeff_writer;

  localparam logic [3:0] HDR = 4'hA;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = '0;
  logic        abort = 1'b0;
  logic        in_ready;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  coeff_writer #(.NUM_TAPS(8), .HDR_TAG(HDR)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_byte  (in_byte),
    .abort    (abort),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [22:0] exp_wr [$];
  int          exp_ev [$];
  int          ir_run = 0;
  logic [15:0] taps [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  // monitor: 1 = done pulse, 2 = err pulse
  always @(negedge clk) begin
    if (!reset) begin
      ir_run = 0;
    end else begin
      if (wr_en) begin
        if (exp_wr.size() == 0) fail("unexpected_write", {9'd0, wr_addr, wr_data});
        else chk("write", {wr_addr, wr_data}, exp_wr.pop_front());
      end
      if (done || err) begin
        chk("done_err_excl", done & err, 0);
        if (exp_ev.size() == 0) fail("unexpected_pulse", {done, err});
        else chk("pulse", done ? 1 : 2, exp_ev.pop_front());
      end
      if (!in_ready) ir_run++;
      else if (ir_run != 0) begin
        chk("commit_ready_low", ir_run, 8);
        ir_run = 0;
      end
    end
  end

  task automatic send(input logic [7:0] b, input int stall);
    int t;
    t = 0;
    while (stall > 0 && $urandom_range(99) < stall && t < 5) begin
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      @(posedge clk); #1;
      t++;
    end
    t = 0;
    while (!in_ready && t < 100) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) fail("ready_timeout", 0);
    in_valid = 1'b1;
    in_byte  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_wr.size() != 0 || exp_ev.size() != 0 || busy) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", exp_wr.size() + exp_ev.size() + int'(busy), 0);
  endtask

  // abort_at < 0: full frame; otherwise abort after abort_at tap bytes
  task automatic send_frame(input logic [3:0] f, input bit flip,
                            input int abort_at, input int stall,
                            input bit rst_mid);
    logic [7:0] b [18];
    logic [7:0] cs;
    int n;
    b[0] = {HDR, f};
    for (int i = 0; i < 8; i++) begin
      b[1 + 2*i] = taps[i][15:8];
      b[2 + 2*i] = taps[i][7:0];
    end
    cs = '0;
    for (int i = 0; i < 17; i++) cs ^= b[i];
    b[17] = cs ^ {7'd0, flip};
    if (abort_at < 0) begin
      if (!flip) begin
        for (int k = 0; k < 8; k++) exp_wr.push_back({f, 3'(k), taps[k]});
        exp_ev.push_back(1);
      end else begin
        exp_ev.push_back(2);
      end
    end
    n = (abort_at < 0) ? 18 : 1 + abort_at;
    for (int i = 0; i < n; i++) send(b[i], stall);
    if (abort_at >= 0) begin
      in_valid = 1'($urandom);
      in_byte  = 8'($urandom);
      abort    = 1'b1;
      @(posedge clk); #1;
      abort    = 1'b0;
      in_valid = 1'b0;
      chk("abort_busy", busy, 0);
      wait_idle();
    end else if (flip) begin
      chk("badcs_busy", busy, 0);
      wait_idle();
    end else if (rst_mid) begin
      repeat (3) @(posedge clk);
      #1;
      chk("fourth_write", {wr_en, wr_addr}, {1'b1, f, 3'd3});
      reset = 1'b0;
      #1;
      exp_wr.delete();
      exp_ev.delete();
      chk("rst_wr", {wr_en, done, err, busy, in_ready}, 5'b00001);
      chk("rst_addr", wr_addr, 0);
      chk("rst_data", wr_data, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_hold", {wr_en, busy}, 0);
      reset = 1'b1;
      @(posedge clk); #1;
    end else begin
      chk("commit_busy", {busy, in_ready}, 2'b10);
      wait_idle();
      chk("hold_addr", wr_addr, {f, 3'd7});
      chk("hold_data", wr_data, taps[7]);
    end
  endtask

  task automatic rand_taps();
    for (int i = 0; i < 8; i++) taps[i] = 16'($urandom);
  endtask

  task automatic bad_header(input logic [7:0] b);
    exp_ev.push_back(2);
    send(b, 0);
    chk("badhdr_busy", busy, 0);
    wait_idle();
  endtask

  initial begin
    logic [7:0] hb;
    int kind;
    #1;
    chk("reset_outs", {wr_en, done, err, busy, in_ready}, 5'b00001);
    chk("reset_addr", wr_addr, 0);
    chk("reset_data", wr_data, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) taps[i] = 16'h0100 + 16'(i);
    send_frame(4'h3, 1'b0, -1, 0, 1'b0);
    send_frame(4'h3, 1'b1, -1, 0, 1'b0);

    bad_header(8'h53);
    rand_taps();
    send_frame(4'hF, 1'b0, -1, 0, 1'b0);

    rand_taps();
    send_frame(4'h6, 1'b0, 5, 0, 1'b0);
    send_frame(4'h6, 1'b0, -1, 0, 1'b0);

    for (int i = 0; i < 8; i++) taps[i] = 16'h0100 + 16'(i);
    send_frame(4'h3, 1'b0, -1, 50, 1'b0);

    in_valid = 1'b1;
    in_byte  = 8'hA3;
    abort    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    abort    = 1'b0;
    chk("idle_abort_busy", busy, 0);
    wait_idle();

    rand_taps();
    send_frame(4'h9, 1'b0, -1, 0, 1'b1);
    rand_taps();
    send_frame(4'h2, 1'b0, -1, 20, 1'b0);

    for (int it = 0; it < 25; it++) begin
      rand_taps();
      kind = $urandom_range(3);
      case (kind)
        0: send_frame(4'($urandom), 1'b0, -1, $urandom_range(60), 1'b0);
        1: send_frame(4'($urandom), 1'b1, -1, $urandom_range(60), 1'b0);
        2: send_frame(4'($urandom), 1'b0, $urandom_range(16),
                      $urandom_range(60), 1'b0);
        default: begin
          hb = 8'($urandom);
          if (hb[7:4] == HDR) hb[7:4] = ~HDR;
          bad_header(hb);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/coeff_writer.md
COEFF_WRITER -- requirements
Module: coeff_writer

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 8, taps per filter; the only supported value is 8.
REQ-002 SHALL have parameter HDR_TAG, default 4'hA, required upper nibble of a frame header byte.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_byte is valid this cycle.
REQ-006 SHALL have port in_byte, input, 8 bits: configuration stream byte.
REQ-007 SHALL have port abort, input, 1 bit: synchronous frame cancel.
REQ-008 SHALL have port in_ready, output, 1 bit: the block can accept a byte.
REQ-009 SHALL have port wr_en, output, 1 bit: coefficient RAM write strobe.
REQ-010 SHALL have port wr_addr, output, 7 bits: RAM word index {filter[3:0], tap[2:0]}.
REQ-011 SHALL have port wr_data, output, 16 bits: tap coefficient.
REQ-012 SHALL have port busy, output, 1 bit: a frame is in progress (state other than IDLE).
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse marking a committed frame.
REQ-014 SHALL have port err, output, 1 bit: one-cycle pulse marking a rejected frame.

Function
REQ-015 SHALL accept a byte only in a cycle with in_valid=1 and in_ready=1.
REQ-016 SHALL use the frame format: header {HDR_TAG, filter[3:0]}, then 16 tap bytes h0..h7 with each tap MSB byte first, then a checksum byte equal to the XOR of the header and all 16 tap bytes.
REQ-017 SHALL implement the states IDLE, LOAD, CHK and COMMIT.
REQ-018 SHALL drive in_ready=1 in IDLE, LOAD and CHK, and in_ready=0 in COMMIT.
REQ-019 IDLE: on an accepted byte whose upper nibble equals HDR_TAG, SHALL latch the filter number, seed the checksum with that byte, clear the byte counter and go to LOAD.
REQ-020 IDLE: on an accepted byte whose upper nibble differs from HDR_TAG, SHALL pulse err the next cycle and stay in IDLE.
REQ-021 LOAD: SHALL store each accepted byte into an 8x16 tap buffer at tap = count[3:1], with the high byte when count[0]=0, and SHALL XOR the byte into the checksum.
REQ-022 LOAD: after the 16th byte is accepted (count=15), SHALL go to CHK.
REQ-023 CHK: if the accepted byte equals the running checksum, SHALL go to COMMIT.
REQ-024 CHK: if the accepted byte differs from the running checksum, SHALL pulse err, perform no RAM write and go to IDLE.
REQ-025 COMMIT: SHALL assert wr_en for exactly 8 consecutive cycles with wr_addr={filter, k} and wr_data=buffer[k] for k=0..7 in order, then go to IDLE.
REQ-026 SHALL pulse done in the first IDLE cycle after the last write.
REQ-027 SHALL drive wr_addr and wr_data from registers; both SHALL hold their last value when wr_en=0.
REQ-028 SHALL leave the tap buffer contents unspecified except for taps written in the current frame.
REQ-029 abort=1 in LOAD or CHK SHALL return the block to IDLE next cycle with no write and no err; any byte presented in that cycle is discarded.
REQ-030 abort in COMMIT SHALL be ignored, so a commit always completes all 8 writes.
REQ-031 abort in IDLE SHALL have no effect and SHALL take priority over a header presented in the same cycle.
REQ-032 in_valid=0 in LOAD or CHK SHALL hold state, count and checksum indefinitely, with no timeout.
REQ-033 done and err SHALL never be asserted in the same cycle.
REQ-034 busy SHALL equal (state != IDLE).

Reset
REQ-035 reset=0 SHALL asynchronously force state IDLE, count 0, checksum 0, filter 0, wr_en 0, wr_addr 0, wr_data 0, done 0 and err 0.
REQ-036 With reset=0, in_ready SHALL be 1 and busy SHALL be 0.
REQ-037 Asserting reset during COMMIT SHALL stop writes immediately, leaving a partial frame; the consumer tolerates this.
REQ-038 Release of reset SHALL take effect on the first rising clk edge after reset returns to 1.

Verification
REQ-039 Scenario, good frame: header 8'hA3, taps 16'h0100..16'h0107, correct checksum -> 8 writes with wr_addr 7'h18..7'h1F and wr_data 16'h0100..16'h0107, then done pulses once.
REQ-040 Scenario, bad checksum: same frame with checksum XOR 8'h01 -> err pulses once, wr_en never asserts, busy falls the next cycle.
REQ-041 Scenario, bad header: byte 8'h53 in IDLE -> err pulse, state stays IDLE; a following valid frame for filter 4'hF writes addresses 7'h78..7'h7F.
REQ-042 Scenario, abort after 5 tap bytes -> no write, no err, busy=0; next frame commits normally.
REQ-043 Scenario, gapped input: in_valid toggling 1/0 with random stalls -> results identical to the good frame; in_ready=0 for exactly 8 cycles during COMMIT.
REQ-044 Scenario, reset asserted at the 4th write cycle -> outputs go to reset values at once; after release, a new frame commits correctly.
